// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner.
// Per-frame BCD snapshot, anti-ghosting gap, leading-zero blanking.
module display_scan_ctrl #(
  parameter int N_DIGITS      = 4,
  parameter int TICK_DIV      = 50000,
  parameter int GAP_CYCLES    = 2,
  parameter bit AN_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          blank_lz,
  input  logic [4*N_DIGITS-1:0]         digits_in,
  input  logic [N_DIGITS-1:0]           dp_in,
  output logic [N_DIGITS-1:0]           an_out,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [1:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [GW-1:0]         gcnt, gcnt_n;
  logic [IW-1:0]         idx_n, idx_inc;
  logic                  load;
  logic [4*N_DIGITS-1:0] snap_dig, dig_n;
  logic [N_DIGITS-1:0]   snap_dp, dp_n;
  logic                  snap_blz, blz_n;
  logic [N_DIGITS-1:0]   blank, onehot;
  logic                  all_zero, lit;
  logic [3:0]            nib;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign idx_inc = (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + 1'b1;

  // Next-state logic; digit_idx advances on leaving SHOW so it holds the next digit during GAP.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    idx_n   = digit_idx;
    load    = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      gcnt_n  = '0;
      idx_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_SHOW;
          cnt_n   = '0;
          idx_n   = '0;
          load    = 1'b1;
        end
        S_SHOW: begin
          if (cnt == CW'(TICK_DIV - 1)) begin
            cnt_n = '0;
            idx_n = idx_inc;
            if (GAP_CYCLES > 0) begin
              state_n = S_GAP;
              gcnt_n  = '0;
            end else begin
              load = (idx_inc == '0);
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GL)) begin
            state_n = S_SHOW;
            gcnt_n  = '0;
            load    = (digit_idx == '0);
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          gcnt_n  = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Snapshot mux plus blanking/decode of the digit that will be driven after this edge.
  always_comb begin
    dig_n    = load ? digits_in : snap_dig;
    dp_n     = load ? dp_in     : snap_dp;
    blz_n    = load ? blank_lz  : snap_blz;
    blank    = '0;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (dig_n[4*k +: 4] == 4'd0);
      blank[k] = blz_n && all_zero;
    end
    onehot        = '0;
    onehot[idx_n] = 1'b1;
    nib           = dig_n[{idx_n, 2'b00} +: 4];
    lit           = (state_n == S_SHOW) && !blank[idx_n];
  end

  // State, counters and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      digit_idx <= '0;
      snap_dig  <= '0;
      snap_dp   <= '0;
      snap_blz  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      digit_idx <= idx_n;
      snap_dig  <= dig_n;
      snap_dp   <= dp_n;
      snap_blz  <= blz_n;
    end
  end

  // Registered pin drivers; dark unless a non-blanked digit is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out  <= AN_OFF;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= lit ? (onehot ^ AN_OFF) : AN_OFF;
      seg_out <= lit ? decode(nib) : 7'h7F;
      dp_out  <= lit ? ~dp_n[idx_n] : 1'b1;
    end
  end

endmodule
